// File: rtl/rs_pkg.sv
// Shared constants for the round/saturate requantizer.
// Rounding mode encodings and the saturation counter width.
package rs_pkg;

  typedef enum logic [1:0] {
    RS_TRUNC     = 2'b00,
    RS_HALF_UP   = 2'b01,
    RS_HALF_EVEN = 2'b10,
    RS_RSVD      = 2'b11
  } rs_mode_e;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/rs_lane.sv
// Per-lane round (pre-register) and saturate (post-register) logic.
// The two halves are independent so the top can put a register between them.
module rs_lane
  import rs_pkg::*;
#(
  parameter int IN_WLEN  = 16,
  parameter int OUT_WLEN = 12,
  parameter int SHIFT_W  = 4,
  parameter int SIGNED   = 1
) (
  input  logic [IN_WLEN-1:0]  din,
  input  logic [SHIFT_W-1:0]  shift,
  input  logic [1:0]          mode,
  output logic [IN_WLEN:0]    rnd,
  input  logic [IN_WLEN:0]    rnd_q,
  output logic [OUT_WLEN-1:0] dout,
  output logic                sat
);

  localparam int W = IN_WLEN + 1;

  localparam logic signed [W-1:0] HI =
    (SIGNED != 0)
      ? {{(W-OUT_WLEN+1){1'b0}}, {(OUT_WLEN-1){1'b1}}}
      : {{(W-OUT_WLEN){1'b0}}, {OUT_WLEN{1'b1}}};

  localparam logic signed [W-1:0] LO =
    (SIGNED != 0)
      ? {{(W-OUT_WLEN+1){1'b1}}, {(OUT_WLEN-1){1'b0}}}
      : '0;

  logic [W-1:0]        ext;
  logic signed [W-1:0] qs;
  logic [IN_WLEN-1:0]  low_m;
  logic [IN_WLEN-1:0]  stk_m;
  logic [IN_WLEN-1:0]  grd_m;
  logic                g;
  logic                t;
  logic                inc;

  // low_m covers the s discarded bits; its top bit is the guard
  always_comb begin
    ext   = {(SIGNED != 0) ? din[IN_WLEN-1] : 1'b0, din};
    qs    = $signed(ext) >>> shift;
    low_m = ~({IN_WLEN{1'b1}} << shift);
    stk_m = low_m >> 1;
    grd_m = low_m ^ stk_m;
    g     = |(din & grd_m);
    t     = |(din & stk_m);
    inc   = 1'b0;
    unique case (1'b1)
      (mode == RS_HALF_UP):   inc = g;
      (mode == RS_HALF_EVEN): inc = g & (t | qs[0]);
      default:                inc = 1'b0;
    endcase
    rnd = qs + W'(inc);
  end

  always_comb begin
    dout = rnd_q[OUT_WLEN-1:0];
    sat  = 1'b0;
    if ($signed(rnd_q) > HI) begin
      dout = HI[OUT_WLEN-1:0];
      sat  = 1'b1;
    end else if ($signed(rnd_q) < LO) begin
      dout = LO[OUT_WLEN-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/round_sat_pipe.sv
// Multi-lane requantizer: round stage, saturate stage, valid/ready
// handshake and a sticky saturation counter.
module round_sat_pipe
  import rs_pkg::*;
#(
  parameter int IN_WLEN  = 16,
  parameter int OUT_WLEN = 12,
  parameter int LANES    = 4,
  parameter int SHIFT_W  = 4,
  parameter int SIGNED   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*IN_WLEN-1:0]  s_data,
  input  logic [SHIFT_W-1:0]        s_shift,
  input  logic [1:0]                s_mode,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*OUT_WLEN-1:0] m_data,
  output logic [LANES-1:0]          m_sat,
  input  logic                      clear_cnt,
  output logic [SAT_CNT_W-1:0]      sat_count
);

  if (OUT_WLEN > IN_WLEN) begin : g_bad_out
    $error("OUT_WLEN must not exceed IN_WLEN");
  end
  if ((1 << SHIFT_W) - 1 > IN_WLEN - 1) begin : g_bad_shift
    $error("SHIFT_W too wide for IN_WLEN");
  end

  logic [LANES-1:0][IN_WLEN-1:0]  lane_in;
  logic [LANES-1:0][IN_WLEN:0]    rnd_d;
  logic [LANES-1:0][IN_WLEN:0]    rnd_q;
  logic [LANES-1:0][OUT_WLEN-1:0] out_d;
  logic [LANES-1:0][OUT_WLEN-1:0] out_q;
  logic [LANES-1:0]               sat_d;
  logic [LANES-1:0]               sat_q;
  logic                           v1;
  logic                           v2;
  logic                           ld2;
  logic                           adv1;
  logic                           take;
  logic                           m_hs;
  logic [SAT_CNT_W-1:0]           cnt_q;

  assign lane_in = s_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rs_lane #(
      .IN_WLEN  (IN_WLEN),
      .OUT_WLEN (OUT_WLEN),
      .SHIFT_W  (SHIFT_W),
      .SIGNED   (SIGNED)
    ) u_lane (
      .din   (lane_in[i]),
      .shift (s_shift),
      .mode  (s_mode),
      .rnd   (rnd_d[i]),
      .rnd_q (rnd_q[i]),
      .dout  (out_d[i]),
      .sat   (sat_d[i])
    );
  end

  assign ld2     = ~v2 | m_ready;
  assign adv1    = v1 & ld2;
  assign s_ready = ~v1 | adv1;
  assign take    = s_valid & s_ready;
  assign m_valid = v2;
  assign m_data  = out_q;
  assign m_sat   = sat_q;
  assign m_hs    = v2 & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      rnd_q <= '0;
    end else if (take) begin
      v1    <= 1'b1;
      rnd_q <= rnd_d;
    end else if (adv1) begin
      v1    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      out_q <= '0;
      sat_q <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        out_q <= out_d;
        sat_q <= sat_d;
      end
    end
  end

  // clear has priority; the count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_cnt) begin
      cnt_q <= '0;
    end else if (m_hs && (|sat_q) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sat_count = cnt_q;

endmodule
